// File: rtl/focus_pkg.sv
// Shared constants, types and helpers for the autofocus sharpness path.
// Window defaults are shared with the overlay and VCM step controller.
package focus_pkg;

    localparam int SCORE_W = 32;
    localparam int CNT_W   = 12;
    localparam int PIX_W   = 8;

    // Luma approximation: Y = (2R + 5G + B) >> 3
    localparam int LUMA_KR    = 2;
    localparam int LUMA_KG    = 5;
    localparam int LUMA_KB    = 1;
    localparam int LUMA_SH    = 3;
    localparam int LUMA_SUM_W = 11;

    // Default centre window and coring threshold
    localparam int WIN_X0_DEF  = 480;
    localparam int WIN_W_DEF   = 320;
    localparam int WIN_Y0_DEF  = 270;
    localparam int WIN_H_DEF   = 180;
    localparam int CORE_TH_DEF = 4;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [CNT_W:0]     cmp_t;
    typedef logic [PIX_W-1:0]   pix_t;
    typedef logic [SCORE_W-1:0] score_t;
    typedef logic [SCORE_W:0]   sum_t;
    typedef logic [LUMA_SUM_W-1:0] lsum_t;

    // Saturating increment for the column/row counters
    function automatic cnt_t cnt_inc(cnt_t v);
        return (&v) ? v : v + cnt_t'(1);
    endfunction

    function automatic pix_t luma(pix_t r, pix_t g, pix_t b);
        lsum_t s;
        s = lsum_t'(LUMA_KR) * lsum_t'(r)
          + lsum_t'(LUMA_KG) * lsum_t'(g)
          + lsum_t'(LUMA_KB) * lsum_t'(b);
        return pix_t'(s >> LUMA_SH);
    endfunction

endpackage

// File: rtl/focus_luma_grad.sv
// Stages 1-2: luma conversion, column counter and horizontal gradient.
// Ports: clk_i/rst_i, de_i + RGB in; x_o (column of the input pixel), dv_o/d_o stage-2 gradient.
module focus_luma_grad
    import focus_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic de_i,
    input  pix_t r_i,
    input  pix_t g_i,
    input  pix_t b_i,
    output cnt_t x_o,
    output logic dv_o,
    output pix_t d_o
);

    logic de_q;
    cnt_t x_q, x_d, x_cur;

    pix_t y1_q, y1_d;
    logic v1_q;
    logic first1_q, first1_d;

    pix_t yprev_q, yprev_d;
    pix_t diff;
    pix_t d2_q, d2_d;
    logic v2_q;

    always_comb begin
        // A DE rising edge starts a new line at column 0
        x_cur    = (de_i && !de_q) ? '0 : x_q;
        x_d      = de_i ? cnt_inc(x_cur) : x_q;
        y1_d     = luma(r_i, g_i, b_i);
        first1_d = (x_cur == '0);
        diff     = (y1_q >= yprev_q) ? (y1_q - yprev_q) : (yprev_q - y1_q);
        // Line-start pixel has no left neighbour
        d2_d     = (v1_q && !first1_q) ? diff : '0;
        yprev_d  = v1_q ? y1_q : yprev_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            de_q     <= 1'b0;
            x_q      <= '0;
            y1_q     <= '0;
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            yprev_q  <= '0;
            d2_q     <= '0;
            v2_q     <= 1'b0;
        end else begin
            de_q     <= de_i;
            x_q      <= x_d;
            y1_q     <= y1_d;
            v1_q     <= de_i;
            first1_q <= first1_d;
            yprev_q  <= yprev_d;
            d2_q     <= d2_d;
            v2_q     <= v1_q;
        end
    end

    assign x_o  = x_cur;
    assign dv_o = v2_q;
    assign d_o  = d2_q;

endmodule

// File: rtl/focus_sharpness_acc.sv
// Per-frame focus metric: windowed, cored gradient sum latched once per frame.
// Ports: VIDEO_* sync/DE + iR/iG/iB in; SCORE/SCORE_VALID/SCORE_SAT, IN_WIN, FRAME_CNT out.
module focus_sharpness_acc
    import focus_pkg::*;
#(
    parameter int WIN_X0  = WIN_X0_DEF,
    parameter int WIN_W   = WIN_W_DEF,
    parameter int WIN_Y0  = WIN_Y0_DEF,
    parameter int WIN_H   = WIN_H_DEF,
    parameter int CORE_TH = CORE_TH_DEF
) (
    input  logic               VIDEO_CLK,
    input  logic               RESET,
    input  logic               VIDEO_VS,
    input  logic               VIDEO_HS,
    input  logic               VIDEO_DE,
    input  logic [PIX_W-1:0]   iR,
    input  logic [PIX_W-1:0]   iG,
    input  logic [PIX_W-1:0]   iB,
    output logic [SCORE_W-1:0] SCORE,
    output logic               SCORE_VALID,
    output logic               SCORE_SAT,
    output logic               IN_WIN,
    output logic [7:0]         FRAME_CNT
);

    localparam cmp_t X_LO = cmp_t'(WIN_X0);
    localparam cmp_t X_HI = cmp_t'(WIN_X0 + WIN_W);
    localparam cmp_t Y_LO = cmp_t'(WIN_Y0);
    localparam cmp_t Y_HI = cmp_t'(WIN_Y0 + WIN_H);
    localparam pix_t TH   = pix_t'(CORE_TH);

    cnt_t x0;
    logic dv2;
    pix_t d2;

    logic vs_q, hs_q, de_q;
    logic vs_fall, hs_fall, line_end;
    cnt_t y_q, y_d, y_cur;
    logic win0, win1_q, win2_q;
    logic fe_q;

    pix_t   contrib;
    sum_t   sum_w;
    logic   clamp;
    score_t acc_sum;
    score_t acc_q, acc_d;
    logic   sat_q, sat_d;
    logic   ok_q, ok_d;
    score_t score_q, score_d;
    logic   ssat_q, ssat_d;
    logic   valid_q, valid_d;
    logic [7:0] fcnt_q, fcnt_d;

    focus_luma_grad u_lg (
        .clk_i (VIDEO_CLK),
        .rst_i (RESET),
        .de_i  (VIDEO_DE),
        .r_i   (iR),
        .g_i   (iG),
        .b_i   (iB),
        .x_o   (x0),
        .dv_o  (dv2),
        .d_o   (d2)
    );

    // Row tracking and window test for the incoming pixel
    always_comb begin
        vs_fall  = vs_q & ~VIDEO_VS;
        hs_fall  = hs_q & ~VIDEO_HS;
        // A line ends when DE drops, or HS falls while still active
        line_end = de_q & (~VIDEO_DE | hs_fall);
        // Pixels arriving with the VS fall already belong to the new frame
        y_cur    = vs_fall ? '0 : y_q;
        y_d      = y_q;
        if (vs_fall) begin
            y_d = '0;
        end else if (line_end) begin
            y_d = cnt_inc(y_q);
        end
        win0 = VIDEO_DE
            && ({1'b0, x0} >= X_LO) && ({1'b0, x0} < X_HI)
            && ({1'b0, y_cur} >= Y_LO) && ({1'b0, y_cur} < Y_HI);
    end

    // Coring, saturating accumulate and frame-end latch
    always_comb begin
        contrib = (dv2 && win2_q && (d2 > TH)) ? (d2 - TH) : '0;
        sum_w   = {1'b0, acc_q} + sum_t'(contrib);
        clamp   = sum_w[SCORE_W];
        acc_sum = clamp ? '1 : sum_w[SCORE_W-1:0];

        acc_d   = acc_sum;
        sat_d   = sat_q | clamp;
        ok_d    = ok_q;
        score_d = score_q;
        ssat_d  = ssat_q;
        valid_d = 1'b0;
        fcnt_d  = fcnt_q;

        if (fe_q) begin
            // The contribution of this cycle closes the old frame
            if (ok_q) begin
                score_d = acc_sum;
                ssat_d  = sat_q | clamp;
                valid_d = 1'b1;
                fcnt_d  = fcnt_q + 8'd1;
            end
            acc_d = '0;
            sat_d = 1'b0;
            ok_d  = 1'b1;
        end
    end

    always_ff @(posedge VIDEO_CLK) begin
        if (RESET) begin
            vs_q   <= 1'b0;
            hs_q   <= 1'b0;
            de_q   <= 1'b0;
            y_q    <= '0;
            win1_q <= 1'b0;
            win2_q <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            vs_q   <= VIDEO_VS;
            hs_q   <= VIDEO_HS;
            de_q   <= VIDEO_DE;
            y_q    <= y_d;
            win1_q <= win0;
            win2_q <= win1_q;
            fe_q   <= vs_fall;
        end
    end

    always_ff @(posedge VIDEO_CLK) begin
        if (RESET) begin
            acc_q   <= '0;
            sat_q   <= 1'b0;
            ok_q    <= 1'b0;
            score_q <= '0;
            ssat_q  <= 1'b0;
            valid_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            ok_q    <= ok_d;
            score_q <= score_d;
            ssat_q  <= ssat_d;
            valid_q <= valid_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign SCORE       = score_q;
    assign SCORE_VALID = valid_q;
    assign SCORE_SAT   = ssat_q;
    assign IN_WIN      = win1_q;
    assign FRAME_CNT   = fcnt_q;

endmodule

// File: tb/tb_focus_sharpness_acc.sv
// Directed-vector bench for focus_sharpness_acc with a small 8x4 frame.
// Window x=2..5, y=1..2, coring threshold 4.
module tb_focus_sharpness_acc;

    localparam int M_FLAT = 0;
    localparam int M_EDGE = 1;
    localparam int M_OUT  = 2;
    localparam int M_G3   = 3;
    localparam int M_G5   = 4;

    logic        VIDEO_CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        VIDEO_VS = 1'b1;
    logic        VIDEO_HS = 1'b1;
    logic        VIDEO_DE = 1'b0;
    logic [7:0]  iR = '0;
    logic [7:0]  iG = '0;
    logic [7:0]  iB = '0;
    logic [31:0] SCORE;
    logic        SCORE_VALID;
    logic        SCORE_SAT;
    logic        IN_WIN;
    logic [7:0]  FRAME_CNT;

    int checks = 0;
    int failures = 0;

    int strobes = 0;
    int dbl = 0;
    logic prev_v = 1'b0;
    logic [31:0] last_score = '0;
    logic last_sat = 1'b0;
    logic [7:0] last_cnt = '0;

    logic drv_de = 1'b0;
    int drv_row = 0;
    int drv_col = 0;
    logic exp_win_q = 1'b0;
    logic win_mon = 1'b0;
    int win_err = 0;
    int win_hi = 0;

    bit got;
    logic [31:0] sc;
    logic st;
    logic [7:0] fc;

    focus_sharpness_acc #(
        .WIN_X0(2), .WIN_W(4), .WIN_Y0(1), .WIN_H(2), .CORE_TH(4)
    ) dut (
        .VIDEO_CLK   (VIDEO_CLK),
        .RESET       (RESET),
        .VIDEO_VS    (VIDEO_VS),
        .VIDEO_HS    (VIDEO_HS),
        .VIDEO_DE    (VIDEO_DE),
        .iR          (iR),
        .iG          (iG),
        .iB          (iB),
        .SCORE       (SCORE),
        .SCORE_VALID (SCORE_VALID),
        .SCORE_SAT   (SCORE_SAT),
        .IN_WIN      (IN_WIN),
        .FRAME_CNT   (FRAME_CNT)
    );

    always #5 VIDEO_CLK = ~VIDEO_CLK;

    // Expected window flag of the pixel that just entered stage 1
    always @(posedge VIDEO_CLK) begin
        exp_win_q <= drv_de && (drv_row >= 1) && (drv_row <= 2)
                  && (drv_col >= 2) && (drv_col <= 5);
    end

    always @(negedge VIDEO_CLK) begin
        if (SCORE_VALID === 1'b1) begin
            strobes++;
            last_score = SCORE;
            last_sat = SCORE_SAT;
            last_cnt = FRAME_CNT;
            if (prev_v) dbl++;
        end
        prev_v = (SCORE_VALID === 1'b1);
        if (win_mon) begin
            if (IN_WIN !== exp_win_q) win_err++;
            if (IN_WIN === 1'b1) win_hi++;
        end
    end

    function automatic logic [7:0] pix(int mode, int r, int c);
        int v;
        case (mode)
            M_FLAT:  v = 100;
            M_EDGE:  v = (c % 2 == 1) ? 200 : 0;
            M_OUT:   v = (r == 0) ? ((c % 2 == 1) ? 200 : 0) : ((c == 0) ? 200 : 0);
            M_G3:    v = 10 + 3 * c;
            M_G5:    v = 10 + 5 * c;
            default: v = 0;
        endcase
        return 8'(v);
    endfunction

    task automatic set_pix(logic [7:0] v);
        iR = v;
        iG = v;
        iB = v;
    endtask

    task automatic frame_lines(int mode);
        for (int r = 0; r < 4; r++) begin
            @(negedge VIDEO_CLK) VIDEO_HS = 1'b0;
            @(negedge VIDEO_CLK) VIDEO_HS = 1'b1;
            @(negedge VIDEO_CLK);
            for (int c = 0; c < 8; c++) begin
                @(negedge VIDEO_CLK);
                VIDEO_DE = 1'b1;
                set_pix(pix(mode, r, c));
                drv_de = 1'b1;
                drv_row = r;
                drv_col = c;
            end
            @(negedge VIDEO_CLK);
            VIDEO_DE = 1'b0;
            drv_de = 1'b0;
            set_pix(8'd0);
            @(negedge VIDEO_CLK);
        end
        repeat (3) @(negedge VIDEO_CLK);
    endtask

    // VS pulse with a fixed observation window for the strobe
    task automatic close_frame(output bit g, output logic [31:0] s,
                               output logic t, output logic [7:0] f);
        int n0;
        n0 = strobes;
        @(negedge VIDEO_CLK) VIDEO_VS = 1'b0;
        @(negedge VIDEO_CLK);
        @(negedge VIDEO_CLK) VIDEO_VS = 1'b1;
        repeat (3) @(negedge VIDEO_CLK);
        g = (strobes == n0 + 1);
        s = last_score;
        t = last_sat;
        f = last_cnt;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        repeat (3) @(negedge VIDEO_CLK);
        checks++; if (SCORE !== 32'd0) begin failures++; $display("FAIL rst_score got=%0h exp=0", SCORE); end
        checks++; if (SCORE_VALID !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", SCORE_VALID); end
        checks++; if (SCORE_SAT !== 1'b0) begin failures++; $display("FAIL rst_sat got=%0b exp=0", SCORE_SAT); end
        checks++; if (IN_WIN !== 1'b0) begin failures++; $display("FAIL rst_inwin got=%0b exp=0", IN_WIN); end
        checks++; if (FRAME_CNT !== 8'd0) begin failures++; $display("FAIL rst_fcnt got=%0d exp=0", FRAME_CNT); end
        RESET = 1'b0;
        repeat (3) @(negedge VIDEO_CLK);
    endtask

    task automatic test_flat;
        close_frame(got, sc, st, fc);
        checks++; if (got !== 1'b0) begin failures++; $display("FAIL flat_arm_strobe got=%0b exp=0", got); end
        frame_lines(M_FLAT);
        close_frame(got, sc, st, fc);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL flat2_strobe got=%0b exp=1", got); end
        checks++; if (sc !== 32'd0) begin failures++; $display("FAIL flat2_score got=%0d exp=0", sc); end
        checks++; if (fc !== 8'd1) begin failures++; $display("FAIL flat2_fcnt got=%0d exp=1", fc); end
        frame_lines(M_FLAT);
        close_frame(got, sc, st, fc);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL flat3_strobe got=%0b exp=1", got); end
        checks++; if (sc !== 32'd0) begin failures++; $display("FAIL flat3_score got=%0d exp=0", sc); end
        checks++; if (fc !== 8'd2) begin failures++; $display("FAIL flat3_fcnt got=%0d exp=2", fc); end
    endtask

    task automatic test_edge;
        frame_lines(M_EDGE);
        close_frame(got, sc, st, fc);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL edge_strobe got=%0b exp=1", got); end
        checks++; if (sc !== 32'd1568) begin failures++; $display("FAIL edge_score got=%0d exp=1568", sc); end
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL edge_sat got=%0b exp=0", st); end
        checks++; if (fc !== 8'd3) begin failures++; $display("FAIL edge_fcnt got=%0d exp=3", fc); end
    endtask

    task automatic test_outside;
        win_err = 0;
        win_hi = 0;
        win_mon = 1'b1;
        frame_lines(M_OUT);
        win_mon = 1'b0;
        checks++; if (SCORE !== 32'd1568) begin failures++; $display("FAIL score_hold got=%0d exp=1568", SCORE); end
        checks++; if (win_err !== 0) begin failures++; $display("FAIL inwin_pattern got=%0d wrong cycles exp=0", win_err); end
        checks++; if (win_hi !== 8) begin failures++; $display("FAIL inwin_count got=%0d exp=8", win_hi); end
        close_frame(got, sc, st, fc);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL out_strobe got=%0b exp=1", got); end
        checks++; if (sc !== 32'd0) begin failures++; $display("FAIL out_score got=%0d exp=0", sc); end
        checks++; if (fc !== 8'd4) begin failures++; $display("FAIL out_fcnt got=%0d exp=4", fc); end
    endtask

    task automatic test_coring;
        frame_lines(M_G3);
        close_frame(got, sc, st, fc);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL g3_strobe got=%0b exp=1", got); end
        checks++; if (sc !== 32'd0) begin failures++; $display("FAIL g3_score got=%0d exp=0", sc); end
        frame_lines(M_G5);
        close_frame(got, sc, st, fc);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL g5_strobe got=%0b exp=1", got); end
        checks++; if (sc !== 32'd8) begin failures++; $display("FAIL g5_score got=%0d exp=8", sc); end
        checks++; if (fc !== 8'd6) begin failures++; $display("FAIL g5_fcnt got=%0d exp=6", fc); end
    endtask

    task automatic test_saturate;
        @(negedge VIDEO_CLK);
        force dut.acc_q = 32'hFFFF_FF00;
        repeat (2) @(negedge VIDEO_CLK);
        release dut.acc_q;
        frame_lines(M_EDGE);
        close_frame(got, sc, st, fc);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL sat_strobe got=%0b exp=1", got); end
        checks++; if (sc !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_score got=%0h exp=ffffffff", sc); end
        checks++; if (st !== 1'b1) begin failures++; $display("FAIL sat_flag got=%0b exp=1", st); end
        frame_lines(M_EDGE);
        close_frame(got, sc, st, fc);
        checks++; if (sc !== 32'd1568) begin failures++; $display("FAIL sat_next_score got=%0d exp=1568", sc); end
        checks++; if (st !== 1'b0) begin failures++; $display("FAIL sat_next_flag got=%0b exp=0", st); end
        checks++; if (fc !== 8'd8) begin failures++; $display("FAIL sat_next_fcnt got=%0d exp=8", fc); end
    endtask

    task automatic test_reset_mid;
        @(negedge VIDEO_CLK) VIDEO_HS = 1'b0;
        @(negedge VIDEO_CLK) VIDEO_HS = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge VIDEO_CLK);
            VIDEO_DE = 1'b1;
            set_pix(pix(M_EDGE, 0, c));
        end
        @(negedge VIDEO_CLK);
        RESET = 1'b1;
        set_pix(pix(M_EDGE, 0, 4));
        @(negedge VIDEO_CLK);
        checks++; if (SCORE !== 32'd0) begin failures++; $display("FAIL mid_rst_score got=%0d exp=0", SCORE); end
        checks++; if (FRAME_CNT !== 8'd0) begin failures++; $display("FAIL mid_rst_fcnt got=%0d exp=0", FRAME_CNT); end
        checks++; if (IN_WIN !== 1'b0) begin failures++; $display("FAIL mid_rst_inwin got=%0b exp=0", IN_WIN); end
        RESET = 1'b0;
        VIDEO_DE = 1'b0;
        set_pix(8'd0);
        repeat (2) @(negedge VIDEO_CLK);
        close_frame(got, sc, st, fc);
        checks++; if (got !== 1'b0) begin failures++; $display("FAIL mid_arm_strobe got=%0b exp=0", got); end
        frame_lines(M_EDGE);
        close_frame(got, sc, st, fc);
        checks++; if (got !== 1'b1) begin failures++; $display("FAIL mid_next_strobe got=%0b exp=1", got); end
        checks++; if (sc !== 32'd1568) begin failures++; $display("FAIL mid_next_score got=%0d exp=1568", sc); end
        checks++; if (fc !== 8'd1) begin failures++; $display("FAIL mid_next_fcnt got=%0d exp=1", fc); end
    endtask

    task automatic test_strobe_width;
        checks++; if (dbl !== 0) begin failures++; $display("FAIL strobe_width got=%0d double strobes exp=0", dbl); end
    endtask

    initial begin
        test_reset;
        test_flat;
        test_edge;
        test_outside;
        test_coring;
        test_saturate;
        test_reset_mid;
        test_strobe_width;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
